phase_discriminator: RTL and testbench

Downstream consumer of the CORDIC arctangent stage's `theta_out`/`valid_out` stream. It turns absolute phase samples into:

- a wrapped per-sample phase difference (instantaneous frequency),
- a running unwrapped phase,
- a block-averaged frequency estimate over 2^LOG_AVG differences.

---
 rtl/phase_pkg.sv | 9 +
 rtl/phase_wrap.sv | 24 ++
 rtl/phase_discriminator.sv | 102 ++++++++++
 tb/tb_phase_discriminator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared phase-domain constants and types for the CORDIC arctangent output stream.
package phase_pkg;
    localparam int PHASE_W    = 16;
    localparam int FRAC_W     = 13;
    localparam int PI_Q13     = 25736;
    localparam int TWO_PI_Q13 = 51472;

    typedef logic signed [PHASE_W-1:0] phase_t;
endpackage

// File: rtl/phase_wrap.sv
// Folds a 17-bit raw phase difference back into [-pi, pi] by a single +/-2pi correction.
module phase_wrap
    import phase_pkg::*;
(
    input  logic signed [PHASE_W:0] raw,
    output phase_t                  wrapped
);
    localparam logic signed [PHASE_W:0] PI_R     = 17'(PI_Q13);
    localparam logic signed [PHASE_W:0] NEG_PI_R = -PI_R;
    localparam logic signed [PHASE_W:0] TWO_PI_R = 17'(TWO_PI_Q13);

    logic signed [PHASE_W:0] adj;

    // Both operands lie in [-pi, pi], so one correction always suffices.
    always_comb begin
        adj = raw;
        if (raw > PI_R) begin
            adj = raw - TWO_PI_R;
        end else if (raw < NEG_PI_R) begin
            adj = raw + TWO_PI_R;
        end
        wrapped = adj[PHASE_W-1:0];
    end
endmodule

// File: rtl/phase_discriminator.sv
// Two-stage phase differencer: wrapped per-sample difference, unwrapped phase and
// a block-averaged frequency estimate over 2^LOG_AVG differences.
module phase_discriminator
    import phase_pkg::*;
#(
    parameter int LOG_AVG  = 2,
    parameter int UNWRAP_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  phase_t                     theta_in,
    input  logic                       valid_in,
    output phase_t                     diff_out,
    output logic                       diff_valid,
    output logic signed [UNWRAP_W-1:0] unwrap_out,
    output phase_t                     freq_out,
    output logic                       freq_valid
);
    localparam int SUM_W = PHASE_W + LOG_AVG;

    logic                       primed;
    phase_t                     prev_theta;
    logic signed [PHASE_W:0]    raw;
    logic                       raw_valid;
    logic signed [UNWRAP_W-1:0] acc;
    logic signed [SUM_W-1:0]    win_sum;
    logic [LOG_AVG-1:0]         win_cnt;

    phase_t                     d;
    logic signed [UNWRAP_W-1:0] d_ext;
    logic signed [UNWRAP_W-1:0] theta_ext;
    logic signed [UNWRAP_W-1:0] acc_next;
    logic signed [SUM_W-1:0]    sum_next;
    logic signed [SUM_W-1:0]    mean_full;

    phase_wrap u_wrap (
        .raw     (raw),
        .wrapped (d)
    );

    assign d_ext     = {{(UNWRAP_W-PHASE_W){d[PHASE_W-1]}}, d};
    assign theta_ext = {{(UNWRAP_W-PHASE_W){theta_in[PHASE_W-1]}}, theta_in};
    assign acc_next  = acc + d_ext;
    assign sum_next  = win_sum + {{LOG_AVG{d[PHASE_W-1]}}, d};
    assign mean_full = sum_next >>> LOG_AVG;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed     <= 1'b0;
            prev_theta <= '0;
            raw        <= '0;
            raw_valid  <= 1'b0;
            acc        <= '0;
            win_sum    <= '0;
            win_cnt    <= '0;
            diff_out   <= '0;
            diff_valid <= 1'b0;
            unwrap_out <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
        end else begin
            diff_valid <= 1'b0;
            freq_valid <= 1'b0;
            raw_valid  <= 1'b0;

            // Stage 2; clear discards whatever sits in stage 1.
            if (clear) begin
                primed  <= 1'b0;
                win_sum <= '0;
                win_cnt <= '0;
            end else if (raw_valid) begin
                diff_out   <= d;
                acc        <= acc_next;
                unwrap_out <= acc_next;
                diff_valid <= 1'b1;
                if (&win_cnt) begin
                    freq_out   <= mean_full[PHASE_W-1:0];
                    freq_valid <= 1'b1;
                    win_sum    <= '0;
                    win_cnt    <= '0;
                end else begin
                    win_sum <= sum_next;
                    win_cnt <= win_cnt + 1'b1;
                end
            end

            // Stage 1; a sample coinciding with clear becomes the new reference.
            if (valid_in) begin
                if (clear || !primed) begin
                    prev_theta <= theta_in;
                    acc        <= theta_ext;
                    primed     <= 1'b1;
                end else begin
                    raw        <= {theta_in[PHASE_W-1], theta_in} - {prev_theta[PHASE_W-1], prev_theta};
                    prev_theta <= theta_in;
                    raw_valid  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_phase_discriminator.sv
// Scoreboard bench for phase_discriminator: directed test-plan scenarios plus random traffic.
module tb_phase_discriminator;
    import phase_pkg::*;

    localparam int LOG_AVG = 2;
    localparam int N       = 1 << LOG_AVG;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    phase_t             theta_in = '0;
    logic               valid_in = 1'b0;
    phase_t             diff_out;
    logic               diff_valid;
    logic signed [31:0] unwrap_out;
    phase_t             freq_out;
    logic               freq_valid;

    phase_discriminator #(.LOG_AVG(LOG_AVG), .UNWRAP_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .theta_in   (theta_in),
        .valid_in   (valid_in),
        .diff_out   (diff_out),
        .diff_valid (diff_valid),
        .unwrap_out (unwrap_out),
        .freq_out   (freq_out),
        .freq_valid (freq_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int exp_edge;
        int diff;
        int unw;
        bit fv;
        int freq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_diff = 0, last_unw = 0, last_freq = 0;

    // Reference model state
    bit   m_primed = 0;
    int   m_prev = 0;
    int   m_unw = 0;
    int   m_win[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int wrap_pi(input int raw);
        int r = raw;
        while (r > PI_Q13) r -= TWO_PI_Q13;
        while (r < -PI_Q13) r += TWO_PI_Q13;
        return r;
    endfunction

    function automatic int floor_mean(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    // Drop expectations for a sample still in stage 1 at the coming edge.
    task automatic kill_inflight();
        while (sb.size() > 0 && sb[$].exp_edge == cyc + 1) void'(sb.pop_back());
    endtask

    task automatic drive(input bit v, input int th, input bit clr);
        exp_t e;
        int   s;
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = v;
        theta_in = 16'(th);
        clear    = clr;
        if (clr) begin
            kill_inflight();
            m_primed = 0;
            m_win.delete();
        end
        if (v) begin
            if (!m_primed) begin
                m_prev   = th;
                m_unw    = th;
                m_primed = 1;
            end else begin
                e.diff = wrap_pi(th - m_prev);
                m_prev = th;
                m_unw  = m_unw + e.diff;
                e.unw  = m_unw;
                e.exp_edge = cyc + 2;
                m_win.push_back(e.diff);
                e.fv   = (m_win.size() == N);
                e.freq = 0;
                if (e.fv) begin
                    s = 0;
                    foreach (m_win[i]) s += m_win[i];
                    e.freq = floor_mean(s);
                    m_win.delete();
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        clear    = 1'b0;
        kill_inflight();
        m_primed = 0;
        m_win.delete();
        @(posedge clk);
        #1;
        chk("reset_diff_out", diff_out, 0);
        chk("reset_unwrap_out", unwrap_out, 0);
        chk("reset_freq_out", freq_out, 0);
        chk("reset_strobes", {diff_valid, freq_valid}, 0);
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].exp_edge < cyc && !diff_valid) begin
                e = sb.pop_front();
                chk("missed_diff_valid", 0, 1);
            end
            if (freq_valid && !diff_valid) chk("freq_without_diff", 1, 0);
            if (diff_valid) begin
                last_diff = diff_out;
                last_unw  = unwrap_out;
                if (freq_valid) last_freq = freq_out;
                if (sb.size() == 0) begin
                    chk("unexpected_diff_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("diff_latency_edge", cyc, e.exp_edge);
                    chk("diff_out", diff_out, e.diff);
                    chk("unwrap_out", unwrap_out, e.unw);
                    chk("freq_valid", freq_valid, e.fv);
                    if (e.fv && freq_valid) chk("freq_out", freq_out, e.freq);
                end
            end
        end
    end

    initial begin
        int th;
        bit v, c;
        repeat (3) @(posedge clk);
        do_reset();

        // Ramp
        for (int i = 0; i < 5; i++) drive(1, i * 1024, 0);
        idle(4);
        chk("ramp_last_unwrap", last_unw, 4096);
        chk("ramp_freq", last_freq, 1024);

        // Wrap across pi
        do_reset();
        drive(1, 24000, 0);
        drive(1, -24000, 0);
        idle(3);
        chk("wrap_pos_diff", last_diff, 3472);
        chk("wrap_pos_unwrap", last_unw, 27472);
        do_reset();
        drive(1, -24000, 0);
        drive(1, 24000, 0);
        idle(3);
        chk("wrap_neg_diff", last_diff, -3472);

        // Averaging rounding
        do_reset();
        drive(1, 0, 0); drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 5, 0);
        idle(3);
        chk("avg_pos_freq", last_freq, 1);
        drive(1, 4, 0); drive(1, 3, 0); drive(1, 2, 0); drive(1, 0, 0);
        idle(3);
        chk("avg_neg_freq", last_freq, -2);

        // Reset mid-window
        do_reset();
        drive(1, 0, 0); drive(1, 100, 0); drive(1, 200, 0);
        idle(3);
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 1000 + i * 500, 0);
        idle(3);
        chk("rst_window_freq", last_freq, 500);

        // Clear with coincident sample
        do_reset();
        drive(1, 5000, 0);
        drive(1, 6000, 0);
        drive(1, 7000, 1);
        drive(1, 7100, 0);
        idle(3);
        chk("clear_diff", last_diff, 100);
        chk("clear_unwrap", last_unw, 7100);

        // Gapped ramp
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, i * 1024, 0);
            idle(3);
        end
        idle(2);
        chk("gap_last_unwrap", last_unw, 4096);
        chk("gap_freq", last_freq, 1024);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v  = ($urandom_range(0, 9) < 7);
                c  = ($urandom_range(0, 39) == 0);
                th = int'($urandom_range(0, 2 * PI_Q13)) - PI_Q13;
                drive(v, th, c);
            end
        end
        idle(6);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
